shift_result_buffer: RTL
========================

Name: shift_result_buffer

Overview:
- Downstream stage of the combinational shifter. Captures each shifter result (`o`) and its operation bit (`shope`) on a valid/ready handshake.
- Holds results in a 2-entry skid buffer and presents them to the ALU writeback/result mux.
- Isolates the shifter's combinational path from downstream backpressure and counts delivered results.

Parameters:
- WIDTH, 32, data width; must match shifter WIDTH.
- CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  shifter result valid
- in_data  in  WIDTH  shifter output o
- in_shope  in  1  shifter operation bit (1 = left, 0 = right), carried as tag
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready
- out_valid  out  1  result available
- out_data  out  WIDTH  buffered result
- out_shope  out  1  tag of out_data
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- o_count  out  CNT_WIDTH  number of results delivered on output since reset
- o_zero  out  1  (only with SHIFT_RESULT_ZERO_FLAG_EN) out_data == 0

Behaviour:
- Storage: main register (drives out_*) and skid register. State enum EMPTY, ONE, FULL.
- Reset (rst_n low at clk edge):
  - state = EMPTY; out_valid = 0; out_data = 0; out_shope = 0; o_count = 0.
  - Skid register cleared.
  - A transfer in flight at reset is discarded; the reset wins over any simultaneous handshake.
- in_ready = (state != FULL), combinational from state only, never from out_ready. Value is 1 in EMPTY after reset.
- out_valid = (state != EMPTY).
- Transitions, where in_fire = in_valid && in_ready and out_fire = out_valid && out_ready:
  - EMPTY, in_fire: main <= in, go to ONE.
  - EMPTY, no in_fire: stay.
  - ONE, in_fire && out_fire: main <= in, stay ONE.
  - ONE, in_fire only: skid <= in, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: main <= skid, go to ONE. in_fire is impossible in FULL since in_ready = 0.
  - FULL, no out_fire: hold all data.
- Latency: a result accepted in cycle N is on out_data in cycle N+1 when the buffer was EMPTY, or when it was ONE with out_fire.
- Throughput: 1 result/cycle when out_ready is held high.
- Ordering: strict FIFO; no result is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_data and out_shope are held stable.
- Counter: o_count increments by 1 on each out_fire and wraps modulo 2^CNT_WIDTH (all-ones + 1 = 0).
- Unused values: in_data is ignored whenever in_fire is 0. Empty registers hold their last value, except after reset, where they are 0.

Optional Feature:
- Macro: SHIFT_RESULT_ZERO_FLAG_EN.
- Defined:
  - Port o_zero exists.
  - The zero flag is computed at capture and stored alongside data in both the main and skid registers.
  - o_zero is registered, aligned with out_data, and resets to 0.
  - o_zero is meaningful only when out_valid = 1.
- Undefined: port o_zero and its storage are absent; all other behaviour is identical.

Decomposition:
- Package shift_result_pkg:
  - typedef enum state_t {EMPTY, ONE, FULL}.
  - typedef struct entry_t {data[WIDTH-1:0], shope, zero (conditional on the macro)}.
  - Localparam default widths.
- No sub-module; the counter and the skid logic are both too small to justify one.
- Top-level integration instantiates shift, then shift_result_buffer. shift's o feeds in_data; shift's shope feeds in_shope.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release. Require in_ready=1, out_valid=0, out_data=0, o_count=0.
- Streaming: out_ready=1; send 0x0000_0001, 0x8000_0000, 0xFFFF_FFFF on consecutive cycles. Require each on out_data one cycle later, in order, and o_count=3.
- Backpressure/FULL:
  - out_ready=0; send 0xA5A5_A5A5 then 0x5A5A_5A5A. Require in_ready=0 from the next cycle and out_data held at 0xA5A5_A5A5.
  - Raise out_ready. Require 0xA5A5_A5A5, then 0x5A5A_5A5A, with in_ready=1 again after the first drain.
- Simultaneous in/out in ONE: with one entry held, assert in_valid and out_ready in the same cycle. Require the new value on out_data next cycle, state still ONE, o_count +1.
- Reset mid-operation: in FULL, pulse rst_n=0 for 1 cycle with in_valid=out_ready=1. Require EMPTY, out_valid=0, o_count=0, and no stale entry emitted afterwards.
- Counter wrap and zero flag (CNT_WIDTH=4, macro defined):
  - Deliver 17 results, the last being 0x0000_0000. Require o_count=1 after the 17th.
  - Require o_zero=1 only while 0x0000_0000 is presented, and o_zero=0 for nonzero results.

Source files
------------

// File: rtl/shift_result_pkg.sv
// ---------------------------------------------------------------------------
// shift_result_pkg
// Shared types and default widths for the shifter result buffer.
//
// Contents:
//   DEFAULT_WIDTH      data width of the shifter result (matches shifter WIDTH)
//   DEFAULT_CNT_WIDTH  width of the delivered-result counter
//   state_t            buffer occupancy: EMPTY, ONE, FULL
//   entry_t            one stored result at default width: data, shope tag and,
//                      when SHIFT_RESULT_ZERO_FLAG_EN is defined, the zero flag
//
// Configuration macro: SHIFT_RESULT_ZERO_FLAG_EN adds the zero field to entry_t.
// ---------------------------------------------------------------------------
package shift_result_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Occupancy of the two-entry skid buffer. EMPTY: nothing presented.
  // ONE: main register valid. FULL: main and skid registers both valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Default-width view of one stored result, for integration code that
  // works at the shifter's standard width.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     shope;
`ifdef SHIFT_RESULT_ZERO_FLAG_EN
    logic                     zero;
`endif
  } entry_t;

endpackage : shift_result_pkg

// File: rtl/shift_result_buffer.sv
// ---------------------------------------------------------------------------
// shift_result_buffer
// Two-entry skid buffer behind the combinational shifter. Captures each
// shifter result and its operation tag on a valid/ready handshake, presents
// them in order to the ALU result mux, and counts delivered results.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid keeps its data
// stable until the transfer; ready may be 1 without valid and carries no
// obligation. in_ready depends only on the registered state, never on
// out_ready, so the shifter's combinational path never sees downstream
// backpressure in the same cycle.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous reset, active-low
//   in_valid   shifter result valid
//   in_data    shifter output o
//   in_shope   shifter operation bit (1 = left, 0 = right), carried as tag
//   in_ready   buffer can accept (state != FULL)
//   out_valid  result available (state != EMPTY)
//   out_data   buffered result (main register)
//   out_shope  tag of out_data
//   out_ready  consumer accepts
//   o_count    results delivered on the output since reset, wraps
//   dbg_state  current occupancy state, for observation only
//   o_zero     out_data == 0, registered with the data
//              (present only with SHIFT_RESULT_ZERO_FLAG_EN)
//
// Configuration macro: SHIFT_RESULT_ZERO_FLAG_EN.
// ---------------------------------------------------------------------------
module shift_result_buffer
  import shift_result_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_shope,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_shope,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] o_count,
  output state_t               dbg_state
`ifdef SHIFT_RESULT_ZERO_FLAG_EN
  ,
  output logic                 o_zero
`endif
);

  // Stored result at this instance's width. The zero flag is computed at
  // capture so the output flag comes straight from a register.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             shope;
`ifdef SHIFT_RESULT_ZERO_FLAG_EN
    logic             zero;
`endif
  } buf_entry_t;

  state_t               state_q;
  buf_entry_t           main_q;
  buf_entry_t           skid_q;
  buf_entry_t           in_entry;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 in_fire;
  logic                 out_fire;

  always_comb begin
    in_entry       = '0;
    in_entry.data  = in_data;
    in_entry.shope = in_shope;
`ifdef SHIFT_RESULT_ZERO_FLAG_EN
    in_entry.zero  = (in_data == '0);
`endif
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Counter wraps naturally at 2^CNT_WIDTH.
  assign count_d = count_q + CNT_WIDTH'(out_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Reset wins over any handshake in the same cycle.
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // Old result leaves as the new one arrives: stay at one entry.
            main_q <= in_entry;
          end else if (in_fire) begin
            // Consumer stalled: park the new result behind the presented one.
            skid_q  <= in_entry;
            state_q <= FULL;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is 0 here, so only the output side can move.
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_data  = main_q.data;
  assign out_shope = main_q.shope;
  assign o_count   = count_q;
  assign dbg_state = state_q;
`ifdef SHIFT_RESULT_ZERO_FLAG_EN
  assign o_zero    = main_q.zero;
`endif

endmodule : shift_result_buffer
